// File: rtl/act_stream1.sv
// Layer-1 activation stage: captures 32 accumulators, applies ReLU/shift/saturate,
// then replays the activations serially to layer 2, framed by start/stop strobes.

module act_lane #(
  parameter int unsigned SHIFT   = 8,
  parameter logic [31:0] SAT_MAX = 32'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic [31:0] p,
  output logic [31:0] act
);
  logic [31:0] r, s, a;

  always_comb begin
    r = p[31] ? '0 : p;
    s = r >> SHIFT;
    a = (s > SAT_MAX) ? SAT_MAX : s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       act <= '0;
    else if (capture) act <= a;
  end
endmodule

module act_stream1 #(
  parameter int unsigned SHIFT   = 8,
  parameter logic [31:0] SAT_MAX = 32'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] p0,  input logic [31:0] p1,  input logic [31:0] p2,  input logic [31:0] p3,
  input  logic [31:0] p4,  input logic [31:0] p5,  input logic [31:0] p6,  input logic [31:0] p7,
  input  logic [31:0] p8,  input logic [31:0] p9,  input logic [31:0] p10, input logic [31:0] p11,
  input  logic [31:0] p12, input logic [31:0] p13, input logic [31:0] p14, input logic [31:0] p15,
  input  logic [31:0] p16, input logic [31:0] p17, input logic [31:0] p18, input logic [31:0] p19,
  input  logic [31:0] p20, input logic [31:0] p21, input logic [31:0] p22, input logic [31:0] p23,
  input  logic [31:0] p24, input logic [31:0] p25, input logic [31:0] p26, input logic [31:0] p27,
  input  logic [31:0] p28, input logic [31:0] p29, input logic [31:0] p30, input logic [31:0] p31,
  output logic [31:0] image,
  output logic        start,
  output logic        stop,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam int NUM_LANES = 32;
  localparam int VEC_W     = 32;

  typedef enum logic [1:0] {IDLE, START, STREAM, STOP} state_t;

  state_t state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic capture;
  logic [NUM_LANES-1:0][VEC_W-1:0] p_vec, act_q;

  assign p_vec = {p31, p30, p29, p28, p27, p26, p25, p24,
                  p23, p22, p21, p20, p19, p18, p17, p16,
                  p15, p14, p13, p12, p11, p10, p9,  p8,
                  p7,  p6,  p5,  p4,  p3,  p2,  p1,  p0};

  assign capture = (state == IDLE) && load;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    act_lane #(.SHIFT(SHIFT), .SAT_MAX(SAT_MAX)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .capture(capture),
      .p      (p_vec[k]),
      .act    (act_q[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Any load that is not a capture counts as an overrun; a capture clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overrun <= 1'b0;
    else if (load) overrun <= (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    image     = '0;
    start     = 1'b0;
    stop      = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = START;
          idx_nxt   = '0;
        end
      end
      START: begin
        start     = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        image   = act_q[idx];
        idx_nxt = idx + 5'd1;
        if (idx == 5'd31) state_nxt = STOP;
      end
      STOP: begin
        stop      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
